// File: rtl/alu_pkg.sv
// Shared ALU/multiplier types for the multicycle MIPS datapath.
// Holds the ALU operation select encoding plus the multiplier FSM state type.
package alu_pkg;

    typedef enum logic [3:0] {
        C_ADD   = 4'd0,
        C_SUB   = 4'd1,
        C_AND   = 4'd2,
        C_OR    = 4'd3,
        C_XOR   = 4'd4,
        C_NOR   = 4'd5,
        C_SLT   = 4'd6,
        C_SLTU  = 4'd7,
        C_SLL   = 4'd8,
        C_SRL   = 4'd9,
        C_SRA   = 4'd10,
        C_LUI   = 4'd11,
        C_MULT  = 4'd12,
        C_MUL_U = 4'd13
    } alu_sel_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_CALC  = 2'd1,
        M_FIXUP = 2'd2
    } mult_state_t;

    localparam int MULT_ITERS = 32;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair with independent write enables and asynchronous reset.
module hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] hi_d_i,
    input  logic [WIDTH-1:0] lo_d_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // HI/LO storage; a disabled half keeps its previous value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= {WIDTH{1'b0}};
            lo_q <= {WIDTH{1'b0}};
        end else begin
            if (hi_we_i) begin
                hi_q <= hi_d_i;
            end
            if (lo_we_i) begin
                lo_q <= lo_d_i;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add 32x32 multiplier (signed/unsigned) writing HI/LO.
// Optional MULT_EARLY_EXIT_EN: leave CALC once the remaining multiplier bits are all zero.
module mult_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = MULT_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_sel_t         opsel,
    input  logic             hi_en,
    input  logic             lo_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             hi_en_q, hi_en_d;
    logic             lo_en_q, lo_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             signed_op_s;
    logic             valid_op_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             early_s;
    logic [PW-1:0]    result_s;
    logic             hi_we_s;
    logic             lo_we_s;

    // Operand decode and sign-magnitude conversion at acceptance
    always_comb begin
        signed_op_s = (opsel == C_MULT);
        valid_op_s  = (opsel == C_MULT) || (opsel == C_MUL_U);
        if (signed_op_s && a[WIDTH-1]) begin
            a_mag_s = ~a + WIDTH'(1);
        end else begin
            a_mag_s = a;
        end
        if (signed_op_s && b[WIDTH-1]) begin
            b_mag_s = ~b + WIDTH'(1);
        end else begin
            b_mag_s = b;
        end
    end

    // Restore the sign of the unsigned magnitude product
    always_comb begin
        if (neg_q) begin
            result_s = ~acc_q + PW'(1);
        end else begin
            result_s = acc_q;
        end
    end

    // Next-state logic and datapath update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_en_d  = hi_en_q;
        lo_en_d  = lo_en_q;
        done_d   = 1'b0;
        hi_we_s  = 1'b0;
        lo_we_s  = 1'b0;
        early_s  = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (start && valid_op_s) begin
                    state_d  = M_CALC;
                    neg_d    = signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                    hi_en_d  = hi_en;
                    lo_en_d  = lo_en;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag_s};
                    mplier_d = b_mag_s;
                    acc_d    = {PW{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    state_d = M_IDLE;
                end
            end
            M_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef MULT_EARLY_EXIT_EN
                early_s  = (mplier_d == {WIDTH{1'b0}});
`else
                early_s  = 1'b0;
`endif
                if ((cnt_q == LAST_CNT) || early_s) begin
                    state_d = M_FIXUP;
                end else begin
                    state_d = M_CALC;
                end
            end
            M_FIXUP: begin
                state_d = M_IDLE;
                hi_we_s = hi_en_q;
                lo_we_s = lo_en_q;
                done_d  = 1'b1;
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase
        busy_d = (state_d != M_IDLE);
    end

    // FSM, datapath and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= M_IDLE;
            acc_q    <= {PW{1'b0}};
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            neg_q    <= 1'b0;
            hi_en_q  <= 1'b0;
            lo_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_en_q  <= hi_en_d;
            lo_en_q  <= lo_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    hilo_reg #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .hi_we_i (hi_we_s),
        .lo_we_i (lo_we_s),
        .hi_d_i  (result_s[PW-1:WIDTH]),
        .lo_d_i  (result_s[WIDTH-1:0]),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed-vector bench for mult_unit: results, latency, enables, start-while-busy and reset.
module tb_mult_unit;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    alu_sel_t    opsel;
    logic        hi_en;
    logic        lo_en;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks_cnt;
    int errors_cnt;
    int lat;
    int ndone;

    mult_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .opsel (opsel),
        .hi_en (hi_en),
        .lo_en (lo_en),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one op at a negedge and watch 50 cycles; optional second start pulse at bump_cycle
    task automatic run_op(input alu_sel_t op, input logic he, input logic le,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int bump_cycle, output int latency, output int dones);
        latency = -1;
        dones   = 0;
        opsel = op; hi_en = he; lo_en = le; a = av; b = bv; start = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = 32'hDEAD_BEEF;
            b = 32'h0BAD_F00D;
            if (i == bump_cycle) begin
                opsel = C_MUL_U; a = 32'd100; b = 32'd100; start = 1'b1;
            end
            if (done) begin
                dones++;
                if (latency < 0) latency = i;
            end
        end
        start = 1'b0;
        opsel = C_ADD;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1; start = 1'b0; opsel = C_ADD; hi_en = 1'b0; lo_en = 1'b0;
        a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned max
        run_op(C_MUL_U, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, ndone);
        check_eq("umax_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        check_eq("umax_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
        check_eq("umax_latency", 64'(lat), 64'd34);
        check_eq("umax_done_cnt", 64'(ndone), 64'd1);

        // Signed negative: -3 * 5
        run_op(C_MULT, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, lat, ndone);
        check_eq("sneg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check_eq("sneg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);

        // Signed corner: (-2^31)^2 = 2^62
        run_op(C_MULT, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, lat, ndone);
        check_eq("scorner_hi", {32'd0, hi}, 64'h0000_0000_4000_0000);
        check_eq("scorner_lo", {32'd0, lo}, 64'd0);

        // Preload HI = 0x12345678 via 0x2468ACF0 * 2^31, then LO-only 7*6
        run_op(C_MUL_U, 1'b1, 1'b1, 32'h2468_ACF0, 32'h8000_0000, 0, lat, ndone);
        check_eq("preload_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        run_op(C_MUL_U, 1'b0, 1'b1, 32'd7, 32'd6, 0, lat, ndone);
        check_eq("part_lo", {32'd0, lo}, 64'd42);
        check_eq("part_hi_kept", {32'd0, hi}, 64'h0000_0000_1234_5678);

        // HI-only signed: 7 * -1 = 0xFFFFFFFF_FFFFFFF9; LO keeps 42
        run_op(C_MULT, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFF, 0, lat, ndone);
        check_eq("hionly_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check_eq("hionly_lo_kept", {32'd0, lo}, 64'd42);

        // Start while busy is ignored and not queued
        run_op(C_MUL_U, 1'b1, 1'b1, 32'd3, 32'd4, 10, lat, ndone);
        check_eq("sbusy_lo", {32'd0, lo}, 64'd12);
        check_eq("sbusy_hi", {32'd0, hi}, 64'd0);
        check_eq("sbusy_done_cnt", 64'(ndone), 64'd1);
        check_eq("sbusy_latency", 64'(lat), 64'd34);

        // Invalid opsel makes start a no-op
        opsel = C_ADD; a = 32'd2; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("badop_busy", {63'd0, busy}, 64'd0);

        // Back-to-back: new start accepted in the done cycle
        opsel = C_MUL_U; hi_en = 1'b1; lo_en = 1'b1; a = 32'd11; b = 32'd13; start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && lat < 0) begin
                lat = i;
                a = 32'd1000; b = 32'd1000; start = 1'b1;
            end
        end
        check_eq("b2b_first_latency", 64'(lat), 64'd34);
        check_eq("b2b_first_lo", {32'd0, lo}, 64'd143);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done && lat < 0) lat = i + 6;
        end
        check_eq("b2b_second_latency", 64'(lat), 64'd34);
        check_eq("b2b_second_lo", {32'd0, lo}, 64'd1000000);

        // Reset at cycle 15 of an operation
        opsel = C_MUL_U; a = 32'd5; b = 32'd5; start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("mid_rst_done", {63'd0, done}, 64'd0);
        check_eq("mid_rst_hi", {32'd0, hi}, 64'd0);
        check_eq("mid_rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("post_rst_lo", {32'd0, lo}, 64'd0);

`ifdef MULT_EARLY_EXIT_EN
        run_op(C_MUL_U, 1'b1, 1'b1, 32'd9, 32'd1, 0, lat, ndone);
        check_eq("early_latency", 64'(lat), 64'd3);
        check_eq("early_lo", {32'd0, lo}, 64'd9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
